// File: rtl/fifo.sv
// Single-clock FIFO, DEPTH = 2**AWIDTH words of DWIDTH bits, registered read data.
// Flags come only from the registered pointers; the extra pointer bit tells full from empty.
module fifo #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                 (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

  // When full, a concurrent read frees the slot the write lands in.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AWIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rd_ptr[AWIDTH-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, single word, fill/drain, simultaneous access, async reset.
module tb_fifo;

  localparam int AWIDTH = 8;
  localparam int DWIDTH = 5;
  localparam int DEPTH  = 2 ** AWIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              rd_en;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              full;
  logic              empty;

  int errors = 0;
  int checks = 0;
  int q[$];
  int exp_dout = 0;
  int held;

  fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given request; reference queue tracks expected contents.
  task automatic do_cycle(input logic w, input logic r, input int d);
    bit rok, wok;
    wr_en   = w;
    rd_en   = r;
    data_in = d[DWIDTH-1:0];
    rok = r && (q.size() > 0);
    wok = w && ((q.size() < DEPTH) || rok);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(d & 31);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 5'd13;
    #23;
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_dout", int'(data_out), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_cycle(0, 1, 0);
    do_cycle(0, 1, 0);
    check("rst_rd_dout", int'(data_out), 0);
    check("rst_rd_empty", int'(empty), 1);

    // single word
    do_cycle(1, 0, 31);
    check("sw_empty", int'(empty), 0);
    check("sw_full", int'(full), 0);
    do_cycle(0, 1, 0);
    check("sw_dout", int'(data_out), 31);
    check("sw_empty_after", int'(empty), 1);
    do_cycle(0, 1, 0);
    check("sw_rd_empty_hold", int'(data_out), 31);

    // fill with 31,30,...,0,31,...
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1, 0, (31 - i) & 31);
      check("fill_full", int'(full), (i == DEPTH - 1) ? 1 : 0);
      check("fill_empty", int'(empty), 0);
    end
    do_cycle(1, 0, 7);
    check("fill_drop_full", int'(full), 1);

    // drain
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(0, 1, 0);
      check("drain_dout", int'(data_out), (31 - i) & 31);
      check("drain_empty", int'(empty), (i == DEPTH - 1) ? 1 : 0);
      check("drain_full", int'(full), 0);
    end
    do_cycle(0, 1, 0);
    check("drain_extra_dout", int'(data_out), 0);
    check("drain_extra_empty", int'(empty), 1);

    // half full, then simultaneous access
    for (int i = 0; i < DEPTH / 2; i++) do_cycle(1, 0, (i * 7 + 3) & 31);
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 1, (i + 17) & 31);
      check("half_dout", int'(data_out), exp_dout);
      check("half_empty", int'(empty), 0);
      check("half_full", int'(full), 0);
    end
    check("half_first_words", exp_dout, (9 * 7 + 3) & 31);
    check("half_occupancy", q.size(), DEPTH / 2);

    // top up to full, simultaneous while full
    for (int i = 0; i < DEPTH / 2; i++) do_cycle(1, 0, (i + 5) & 31);
    check("top_full", int'(full), 1);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 1, (i * 11) & 31);
      check("fullrw_dout", int'(data_out), exp_dout);
      check("fullrw_full", int'(full), 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(0, 1, 0);
      check("fulldrain_dout", int'(data_out), exp_dout);
    end
    check("fulldrain_empty", int'(empty), 1);
    check("fulldrain_last", int'(data_out), 22);

    // simultaneous while empty
    held = int'(data_out);
    do_cycle(1, 1, 9);
    check("emptyrw_hold", int'(data_out), held);
    check("emptyrw_empty", int'(empty), 0);
    do_cycle(0, 1, 0);
    check("emptyrw_read", int'(data_out), 9);
    check("emptyrw_empty2", int'(empty), 1);

    // async reset mid-stream with 100 words held
    for (int i = 0; i < 100; i++) do_cycle(1, 0, (i + 1) & 31);
    do_cycle(0, 1, 0);
    check("pre_rst_dout", int'(data_out), 1);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_full", int'(full), 0);
    check("mid_rst_dout", int'(data_out), 0);
    q.delete();
    exp_dout = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_cycle(1, 0, 21);
    check("post_rst_empty", int'(empty), 0);
    do_cycle(0, 1, 0);
    check("post_rst_dout", int'(data_out), 21);
    check("post_rst_empty2", int'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock first-in first-out buffer with DEPTH = 2**AWIDTH entries of DWIDTH bits.
- Sits between a producer and a consumer in the same clock domain.
- Producer writes with wr_en; consumer pops with rd_en and receives the word on a registered output.
- full and empty status flags provide flow control.

Parameters:
- AWIDTH, default 8: address width; storage depth DEPTH = 2**AWIDTH (default 256).
- DWIDTH, default 5: data word width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request; pushes data_in on a rising edge when accepted.
- rd_en  input  1  read request; pops the oldest word to data_out on a rising edge when accepted.
- data_in  input  DWIDTH  write data.
- data_out  output  DWIDTH  registered read data.
- full  output  1  high when DEPTH words are stored.
- empty  output  1  high when zero words are stored.

Behaviour:
- Storage: DEPTH x DWIDTH memory array; contents are not reset.
- Write pointer and read pointer: AWIDTH+1 bits each (extra wrap bit); the low AWIDTH bits address the memory.
- Reset: rst low asynchronously sets both pointers to 0 and data_out to 0. Resulting outputs: empty=1, full=0.
- Reset mid-operation discards all stored words immediately; no clock is required.
- Flags are decoded only from the registered pointers, with no combinational path from wr_en/rd_en.
  - empty = (wr_ptr == rd_ptr).
  - full = (low AWIDTH bits equal) and (wrap bits differ).
- Write accepted when wr_en=1 and full=0: mem[wr_ptr] <= data_in, wr_ptr increments by 1 modulo 2**(AWIDTH+1).
- Write rejected when full=1 (and no simultaneous accepted read): memory and pointer are unchanged and the word is dropped.
- Read accepted when rd_en=1 and empty=0: data_out <= mem[rd_ptr] on that edge, rd_ptr increments.
- Read latency is one clock: data is valid after the edge that accepts the read.
- Read on empty: ignored; rd_ptr unchanged and data_out holds its previous value.
- data_out holds its last read value whenever no read is accepted.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both performed. Occupancy is unchanged and flags are unchanged.
  - Full: both performed. The read returns the oldest word, the write fills the freed slot, and full stays 1.
  - Empty: only the write is performed. data_out holds, and the next cycle has empty=0.
- Flag timing: flags update in the cycle after the accepting edge.
  - empty deasserts after the first write.
  - full asserts after the DEPTH-th net write.
  - empty asserts after the last stored word is read.
- Wrap-around: pointers wrap transparently; data order is preserved across any number of wraps.
- Data is opaque: no arithmetic is applied; DWIDTH bits pass unchanged.

Test Plan:
- Reset: drive rst=0 with arbitrary inputs, then release -> empty=1, full=0, data_out=0 with no clock edge needed; extra rd_en pulses leave data_out=0.
- Single word:
  - Write 5'd31 for one cycle -> empty=0, full=0.
  - Then read one cycle -> data_out=31, empty=1.
  - A following read with the FIFO empty -> data_out stays 31.
- Fill:
  - Write 256 consecutive words 31,30,...,0,31,... (decrementing mod 32) -> full=1 only after the 256th write.
  - A 257th write with data_in=7 is dropped.
- Drain:
  - Read 257 consecutive cycles -> data_out sequence 31,30,...,0,31,... (256 words, 256th = 0).
  - empty=1 after the 256th read; the 257th read holds data_out=0.
- Simultaneous access:
  - At half-full (128 words): wr_en=rd_en=1 for 10 cycles -> occupancy stays 128, flags unchanged, order preserved.
  - When full with both asserted: full stays 1, oldest word is read.
  - When empty with both asserted: write occurs, data_out unchanged.
- Async reset mid-stream: assert rst low between clock edges while holding 100 words -> empty=1, full=0, data_out=0 immediately; the subsequent write/read returns the new word.
